instr_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 32 +++
 rtl/instr_fields.sv | 22 ++
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_instr_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, word field layout,
// FSM state encoding and a saturating counter helper.
package seq_pkg;

    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_AND   = 8'h03;
    localparam logic [7:0] OP_OR    = 8'h04;
    localparam logic [7:0] OP_LOAD  = 8'h05;
    localparam logic [7:0] OP_STORE = 8'h06;
    localparam logic [7:0] OP_JMP   = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int FIELD_W = 8;
    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 16;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } seq_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a 32-bit instruction word into its four byte fields,
// with flags for the two opcodes the sequencer handles itself.
module instr_fields
    import seq_pkg::*;
(
    input  logic [31:0]        word_i,
    output logic [FIELD_W-1:0] opcode_o,
    output logic [FIELD_W-1:0] rd_o,
    output logic [FIELD_W-1:0] rs1_o,
    output logic [FIELD_W-1:0] rs2_o,
    output logic               is_jmp_o,
    output logic               is_halt_o
);

    assign opcode_o  = word_i[OPC_LSB +: FIELD_W];
    assign rd_o      = word_i[RD_LSB  +: FIELD_W];
    assign rs1_o     = word_i[RS1_LSB +: FIELD_W];
    assign rs2_o     = word_i[RS2_LSB +: FIELD_W];
    assign is_jmp_o  = (opcode_o == OP_JMP);
    assign is_halt_o = (opcode_o == OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch-and-issue unit: fetches words, issues decoded fields over valid/ready.
// Optional macro SEQ_JUMP_EN resolves JMP (opcode 0x07) locally instead of issuing it.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            issue_valid,
    output logic [7:0]      issue_opcode,
    output logic [7:0]      issue_rd,
    output logic [7:0]      issue_rs1,
    output logic [7:0]      issue_rs2,
    input  logic            issue_ready,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     instr_count
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      opc_q, opc_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic            req_q, req_d, vld_q, vld_d, halt_q, halt_d;

    logic [7:0] f_opc, f_rd, f_rs1, f_rs2;
    logic       f_is_jmp, f_is_halt;

    instr_fields u_fields (
        .word_i    (imem_rdata),
        .opcode_o  (f_opc),
        .rd_o      (f_rd),
        .rs1_o     (f_rs1),
        .rs2_o     (f_rs2),
        .is_jmp_o  (f_is_jmp),
        .is_halt_o (f_is_halt)
    );

`ifdef SEQ_JUMP_EN
    // Jump target is rs2, truncated or zero-extended to the PC width.
    logic [PC_W-1:0] jmp_tgt;
    generate
        if (PC_W <= 8) begin : g_tgt_trunc
            assign jmp_tgt = f_rs2[PC_W-1:0];
        end else begin : g_tgt_ext
            assign jmp_tgt = {{(PC_W-8){1'b0}}, f_rs2};
        end
    endgenerate
`else
    logic unused_jmp;
    assign unused_jmp = f_is_jmp;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_valid) begin
                    if (f_is_halt) begin
                        state_d = S_HALT;
`ifdef SEQ_JUMP_EN
                    end else if (f_is_jmp) begin
                        pc_d    = jmp_tgt;
                        state_d = S_FETCH;
`endif
                    end else begin
                        opc_d   = f_opc;
                        rd_d    = f_rd;
                        rs1_d   = f_rs1;
                        rs2_d   = f_rs2;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    pc_d    = pc_q + PC_W'(1);
                    cnt_d   = sat_inc16(cnt_q);
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered copies of the state being entered.
        req_d  = (state_d == S_FETCH);
        vld_d  = (state_d == S_ISSUE);
        halt_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            opc_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            halt_q  <= halt_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign issue_valid  = vld_q;
    assign issue_opcode = opc_q;
    assign issue_rd     = rd_q;
    assign issue_rs1    = rs1_q;
    assign issue_rs2    = rs2_q;
    assign halted       = halt_q;
    assign pc           = pc_q;
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default PC_W=8, RESET_PC=0),
// covering both SEQ_JUMP_EN builds.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_req, imem_valid, issue_valid, issue_ready, halted;
    logic [7:0]  imem_addr, pc, issue_opcode, issue_rd, issue_rs1, issue_rs2;
    logic [31:0] imem_rdata;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEQ_JUMP_EN
    localparam int CNT_AFTER_WRAP = 3;
`else
    localparam int CNT_AFTER_WRAP = 256;
`endif

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_ready  (issue_ready),
        .halted       (halted),
        .pc           (pc),
        .instr_count  (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fetch, check its address, then return w after dly WAIT cycles.
    // Returns in the cycle following the accepting edge.
    task automatic serve(input logic [31:0] w, input logic [7:0] exp_addr, input int dly);
        int t = 0;
        while (imem_req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
        step();
        for (int i = 1; i < dly; i++) step();
        imem_valid = 1'b1;
        imem_rdata = w;
        step();
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
    endtask

    initial begin
        logic saw_req;
        rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0; issue_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_cnt", {16'd0, instr_count}, 32'd0);
        chk("rst_opcode", {24'd0, issue_opcode}, 32'd0);

        // First instruction, fastest memory, ready high
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_req", {31'd0, imem_req}, 32'd1);
        issue_ready = 1'b1;
        serve(32'h01030102, 8'h00, 1);
        chk("t1_valid", {31'd0, issue_valid}, 32'd1);
        chk("t1_opcode", {24'd0, issue_opcode}, 32'h01);
        chk("t1_rd", {24'd0, issue_rd}, 32'h03);
        chk("t1_rs1", {24'd0, issue_rs1}, 32'h01);
        chk("t1_rs2", {24'd0, issue_rs2}, 32'h02);
        chk("t1_pc_hold", {24'd0, pc}, 32'd0);
        step();
        chk("t1_valid_drop", {31'd0, issue_valid}, 32'd0);
        chk("t1_pc", {24'd0, pc}, 32'd1);
        chk("t1_cnt", {16'd0, instr_count}, 32'd1);

        // Back-pressure: ready low 4 cycles, slow memory
        issue_ready = 1'b0;
        serve(32'h02050607, 8'h01, 2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, issue_valid}, 32'd1);
            chk("bp_fields", {issue_opcode, issue_rd, issue_rs1, issue_rs2}, 32'h02050607);
            chk("bp_pc", {24'd0, pc}, 32'd1);
            step();
        end
        issue_ready = 1'b1;
        chk("bp_valid_last", {31'd0, issue_valid}, 32'd1);
        step();
        chk("bp_pc_after", {24'd0, pc}, 32'd2);
        chk("bp_cnt_after", {16'd0, instr_count}, 32'd2);

        // JMP at pc=2
        serve(32'h07000010, 8'h02, 1);
`ifdef SEQ_JUMP_EN
        chk("jmp_no_issue", {31'd0, issue_valid}, 32'd0);
        chk("jmp_req", {31'd0, imem_req}, 32'd1);
        chk("jmp_addr", {24'd0, imem_addr}, 32'h10);
        chk("jmp_cnt", {16'd0, instr_count}, 32'd2);
        serve(32'h070000FF, 8'h10, 1);
        chk("jmp2_addr", {24'd0, imem_addr}, 32'hFF);
        serve(32'h01000000, 8'hFF, 1);
        step();
`else
        chk("jmp_issued", {31'd0, issue_valid}, 32'd1);
        chk("jmp_opcode", {24'd0, issue_opcode}, 32'h07);
        step();
        chk("jmp_pc", {24'd0, pc}, 32'd3);
        chk("jmp_cnt", {16'd0, instr_count}, 32'd3);
        for (int a = 3; a < 256; a++) begin
            serve(32'h01000000, a[7:0], 1);
            step();
        end
`endif
        // PC wrap after ADD at 0xFF
        chk("wrap_pc", {24'd0, pc}, 32'd0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", {24'd0, imem_addr}, 32'd0);
        chk("wrap_cnt", {16'd0, instr_count}, CNT_AFTER_WRAP);

        // HALT, later start ignored, reset releases
        serve(32'hFF000000, 8'h00, 1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_no_issue", {31'd0, issue_valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req === 1'b1) saw_req = 1'b1;
            step();
        end
        chk("halt_no_fetch", {31'd0, saw_req}, 32'd0);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        chk("halt_cnt", {16'd0, instr_count}, CNT_AFTER_WRAP);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("hrst_halted", {31'd0, halted}, 32'd0);
        chk("hrst_pc", {24'd0, pc}, 32'd0);
        chk("hrst_cnt", {16'd0, instr_count}, 32'd0);
        step(); step();
        chk("hrst_idle", {31'd0, imem_req}, 32'd0);

        // Reset while in WAIT, late imem_valid ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("w_fetch", {31'd0, imem_req}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h01030102;
        step();
        imem_valid = 1'b0;
        imem_rdata = '0;
        chk("w_no_issue", {31'd0, issue_valid}, 32'd0);
        chk("w_pc", {24'd0, pc}, 32'd0);
        chk("w_no_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("w_no_issue2", {31'd0, issue_valid}, 32'd0);
        chk("w_opcode", {24'd0, issue_opcode}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
